// File: rtl/sequence_generator.sv
// Framed serial transmitter: SYNC_PAT (3 bits, MSB first), then DATA_W payload bits (MSB first).
// Define SEQGEN_PARITY_EN to append an even-parity bit after the payload (state PAR).
module sequence_generator #(
  parameter int         DATA_W   = 8,
  parameter logic [2:0] SYNC_PAT = 3'b110
) (
  input  logic              clk,
  input  logic              RD,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              X,
  output logic              busy,
  output logic              frame_done
);

`ifdef SEQGEN_PARITY_EN
  localparam int FRAME_LEN = 4 + DATA_W;
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_e;
`else
  localparam int FRAME_LEN = 3 + DATA_W;
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_e;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W + 2);
  localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(2);
  localparam logic [CNT_W-1:0] SYNC_MID  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;    // index of the frame bit currently on X
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              x_q, x_d;
`ifdef SEQGEN_PARITY_EN
  logic              par_q, par_d;
`endif
  logic              last_bit;
  logic              accept;

  assign last_bit   = (state_q != IDLE) && (cnt_q == LAST_IDX);
  assign din_ready  = RD && ((state_q == IDLE) || last_bit);
  assign accept     = din_valid && din_ready;
  assign X          = x_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = last_bit;

  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    x_d     = x_q;
`ifdef SEQGEN_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: ;
      SYNC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SYNC_END) begin
          state_d = DATA;
          x_d     = sh_q[DATA_W-1];
          sh_d    = {sh_q[DATA_W-2:0], 1'b0};
        end else begin
          x_d = (cnt_q == SYNC_MID) ? SYNC_PAT[0] : SYNC_PAT[1];
        end
      end
      DATA: begin
        if (cnt_q != LAST_DATA) begin
          cnt_d = cnt_q + 1'b1;
          x_d   = sh_q[DATA_W-1];
          sh_d  = {sh_q[DATA_W-2:0], 1'b0};
        end
`ifdef SEQGEN_PARITY_EN
        else begin
          state_d = PAR;
          cnt_d   = cnt_q + 1'b1;
          x_d     = par_q;
        end
`endif
      end
`ifdef SEQGEN_PARITY_EN
      PAR: ;
`endif
      default: state_d = IDLE;
    endcase

    // Frame end: fall back to idle unless a new word is taken on this same
    // edge, in which case the next frame starts with no gap.
    if (last_bit) begin
      state_d = IDLE;
      cnt_d   = '0;
      sh_d    = '0;
      x_d     = 1'b0;
`ifdef SEQGEN_PARITY_EN
      par_d   = 1'b0;
`endif
    end
    if (accept) begin
      state_d = SYNC;
      cnt_d   = '0;
      sh_d    = din;
      x_d     = SYNC_PAT[2];
`ifdef SEQGEN_PARITY_EN
      par_d   = ^din;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk or negedge RD) begin
    if (!RD) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      x_q     <= 1'b0;
`ifdef SEQGEN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      x_q     <= x_d;
`ifdef SEQGEN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter: DATA_W, default 8, payload bits per frame (legal range 2..16).
REQ-002 Parameter: SYNC_PAT, default 3'b110, 3-bit frame sync pattern, sent MSB first.
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: RD  in  1  reset; asynchronous, active-low.
REQ-005 Port: din  in  DATA_W  parallel payload word.
REQ-006 Port: din_valid  in  1  din holds a word to send.
REQ-007 Port: din_ready  out  1  block accepts din this cycle.
REQ-008 Port: X  out  1  registered serial output stream; drives a sequence_detector X input.
REQ-009 Port: busy  out  1  frame in progress.
REQ-010 Port: frame_done  out  1  single-cycle pulse during the last bit of each frame.

Function
REQ-011 States SHALL be IDLE, SYNC, DATA and PAR; PAR exists only per REQ-024.
REQ-012 Handshake: a word SHALL be accepted on a rising edge where din_valid=1 and din_ready=1; din is captured into a shift register on that edge.
REQ-013 din_ready SHALL be 1 in IDLE and during the last bit cycle of a frame, and 0 otherwise and while RD=0.
REQ-014 Latency: X SHALL present the first SYNC_PAT bit in the cycle right after the accept edge.
REQ-015 Frame order: 3 SYNC_PAT bits (MSB first), then DATA_W payload bits (MSB first), then the parity bit if enabled; each bit lasts exactly one clock.
REQ-016 Frame length SHALL be 3+DATA_W cycles, or 4+DATA_W with parity; bit counter SHALL wrap to 0 at frame end.
REQ-017 In IDLE, X SHALL be 0 and busy SHALL be 0; busy SHALL be 1 in every SYNC/DATA/PAR cycle.
REQ-018 Back-to-back: if a word is accepted during the last bit, the next frame's first sync bit SHALL follow with no idle gap.
REQ-019 If no word is accepted during the last bit, the next state SHALL be IDLE and X SHALL return to 0.
REQ-020 din and din_valid SHALL be ignored outside accept cycles; a held din_valid SHALL NOT cause duplicate acceptance.
REQ-021 frame_done SHALL be 1 only in the cycle where the final frame bit is on X.

Reset
REQ-022 RD=0 SHALL immediately force the state to IDLE and set X=0, busy=0, frame_done=0, din_ready=0, with the bit counter and shift register at 0, regardless of clk.
REQ-023 Reset mid-frame SHALL abort the frame with no further bits; after RD rises, the first rising edge with din_valid=1 SHALL start a fresh frame.

Configuration
REQ-024 Macro SEQGEN_PARITY_EN: when defined, an even-parity bit (XOR of the payload) SHALL follow the payload in state PAR; when undefined, PAR and the parity logic SHALL be absent and the frame is 3+DATA_W bits.

Verification
REQ-025 Defaults, macro undefined, din=8'hA5 accepted once -> X = 1,1,0,1,0,1,0,0,1,0,1 over 11 cycles, then 0; frame_done in cycle 11 only; busy high for cycles 1-11.
REQ-026 SEQGEN_PARITY_EN defined, din=8'h07 -> X = 1,1,0,0,0,0,0,0,1,1,1,1 (parity 1); frame_done in cycle 12.
REQ-027 din_valid held 1 with 8'hFF then 8'h00 -> 22 contiguous cycles 1,1,0,1x8,1,1,0,0x8; din_ready high only in cycles 11 and 22 (and IDLE).
REQ-028 RD pulled low in payload cycle 5 of 8'hA5 -> X=0, busy=0 and din_ready=0 at once; after release, 8'h3C produces a complete clean frame.
REQ-029 Loopback into sequence_detector with 8'hA5 -> detector Y asserted exactly once, in frame cycle 3 (the sync 0 bit).
REQ-030 din_valid=1 with din_ready=0 mid-frame, changing din each cycle -> transmitted payload equals the word captured at the accept edge.
